// File: rtl/tmds_encoder.sv
// TMDS 8b/10b channel encoder: transition minimisation, running-disparity DC balance, control tokens.
// Two-stage pipeline; o_word[0] is the first bit on the wire. Define TMDS_TERC4_EN for HDMI data-island TERC4.
module tmds_encoder (
  input  logic       i_pix_clk,
  input  logic       i_reset,
  input  logic       i_de,
  input  logic [1:0] i_ctl,
  input  logic [7:0] i_data,
`ifdef TMDS_TERC4_EN
  input  logic       i_island,
  input  logic [3:0] i_aux,
`endif
  output logic [9:0] o_word,
  output logic [5:0] o_disparity
);

  localparam logic [9:0] CTL_TOKEN_00 = 10'b1101010100;

  function automatic logic [9:0] ctl_token(input logic [1:0] ctl);
    case (ctl)
      2'b00:   ctl_token = 10'b1101010100;
      2'b01:   ctl_token = 10'b0010101011;
      2'b10:   ctl_token = 10'b0101010100;
      default: ctl_token = 10'b1010101011;
    endcase
  endfunction

`ifdef TMDS_TERC4_EN
  function automatic logic [9:0] terc4(input logic [3:0] aux);
    case (aux)
      4'h0:    terc4 = 10'b1010011100;
      4'h1:    terc4 = 10'b1001100011;
      4'h2:    terc4 = 10'b1011100100;
      4'h3:    terc4 = 10'b1011100010;
      4'h4:    terc4 = 10'b0101110001;
      4'h5:    terc4 = 10'b0100011110;
      4'h6:    terc4 = 10'b0110001110;
      4'h7:    terc4 = 10'b0100111100;
      4'h8:    terc4 = 10'b1011001100;
      4'h9:    terc4 = 10'b0100111001;
      4'hA:    terc4 = 10'b0110011100;
      4'hB:    terc4 = 10'b1011000110;
      4'hC:    terc4 = 10'b1010001110;
      4'hD:    terc4 = 10'b1001110001;
      4'hE:    terc4 = 10'b0101100011;
      default: terc4 = 10'b1011000011;
    endcase
  endfunction
`endif

  // ---------------- stage 1: transition minimisation ----------------
  logic [3:0] n1d;
  logic       xnor_mode;
  logic [7:0] qm_next;
  logic [3:0] n1q_next;

  always_comb begin
    n1d = '0;
    for (int i = 0; i < 8; i++) n1d = n1d + {3'b000, i_data[i]};
  end

  assign xnor_mode = (n1d > 4'd4) || ((n1d == 4'd4) && !i_data[0]);

  // The XOR/XNOR chain unrolls to a prefix parity; every XNOR step adds one inversion.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_qm
      assign qm_next[gi] = (^i_data[gi:0]) ^ (xnor_mode & (gi % 2 == 1));
    end
  endgenerate

  always_comb begin
    n1q_next = '0;
    for (int i = 0; i < 8; i++) n1q_next = n1q_next + {3'b000, qm_next[i]};
  end

  logic [8:0] qm_reg;
  logic [3:0] n1q_reg;
  logic       de_reg;
  logic [1:0] ctl_reg;
`ifdef TMDS_TERC4_EN
  logic       island_reg;
  logic [3:0] aux_reg;
`endif

  always_ff @(posedge i_pix_clk or posedge i_reset) begin
    if (i_reset) begin
      qm_reg     <= '0;
      n1q_reg    <= '0;
      de_reg     <= 1'b0;
      ctl_reg    <= 2'b00;
`ifdef TMDS_TERC4_EN
      island_reg <= 1'b0;
      aux_reg    <= '0;
`endif
    end else begin
      qm_reg     <= {~xnor_mode, qm_next};
      n1q_reg    <= n1q_next;
      de_reg     <= i_de;
      ctl_reg    <= i_ctl;
`ifdef TMDS_TERC4_EN
      island_reg <= i_island;
      aux_reg    <= i_aux;
`endif
    end
  end

  // ---------------- stage 2: DC balance ----------------
  logic [9:0]        word_reg, word_next;
  logic signed [5:0] cnt_reg, cnt_next;
  logic signed [5:0] n1q_s, diff;

  always_comb begin
    n1q_s     = {2'b00, n1q_reg};
    diff      = n1q_s - (6'sd8 - n1q_s);  // N1q - N0q
    word_next = ctl_token(ctl_reg);
    cnt_next  = '0;
    if (de_reg) begin
      if ((cnt_reg == 6'sd0) || (n1q_reg == 4'd4)) begin
        word_next = {~qm_reg[8], qm_reg[8], qm_reg[8] ? qm_reg[7:0] : ~qm_reg[7:0]};
        cnt_next  = qm_reg[8] ? (cnt_reg + diff) : (cnt_reg - diff);
      end else if (((cnt_reg > 6'sd0) && (n1q_reg > 4'd4)) ||
                   ((cnt_reg < 6'sd0) && (n1q_reg < 4'd4))) begin
        word_next = {1'b1, qm_reg[8], ~qm_reg[7:0]};
        cnt_next  = cnt_reg + (qm_reg[8] ? 6'sd2 : 6'sd0) - diff;
      end else begin
        word_next = {1'b0, qm_reg[8], qm_reg[7:0]};
        cnt_next  = cnt_reg + diff - (qm_reg[8] ? 6'sd0 : 6'sd2);
      end
    end
`ifdef TMDS_TERC4_EN
    else if (island_reg) begin
      word_next = terc4(aux_reg);
    end
`endif
  end

  always_ff @(posedge i_pix_clk or posedge i_reset) begin
    if (i_reset) begin
      word_reg <= CTL_TOKEN_00;
      cnt_reg  <= '0;
    end else begin
      word_reg <= word_next;
      cnt_reg  <= cnt_next;
    end
  end

  assign o_word      = word_reg;
  assign o_disparity = cnt_reg;

endmodule

// File: tb/tb_tmds_encoder.sv
// Scoreboard bench for tmds_encoder: directed hand-computed vectors, a modelled random burst,
// mid-line reset, and (with TMDS_TERC4_EN) the TERC4 island table.
module tb_tmds_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       de;
  logic [1:0] ctl;
  logic [7:0] data;
`ifdef TMDS_TERC4_EN
  logic       island;
  logic [3:0] aux;
`endif
  logic [9:0] word;
  logic [5:0] disp;

  always #5 clk = ~clk;

  tmds_encoder dut (
    .i_pix_clk  (clk),
    .i_reset    (rst),
    .i_de       (de),
    .i_ctl      (ctl),
    .i_data     (data),
`ifdef TMDS_TERC4_EN
    .i_island   (island),
    .i_aux      (aux),
`endif
    .o_word     (word),
    .o_disparity(disp)
  );

  typedef struct {
    int         due;
    logic [9:0] word;
    logic [5:0] disp;
    bit         has_data;
    logic [7:0] data;
  } exp_t;

  typedef struct packed {
    logic       de;
    logic [1:0] ctl;
    logic [7:0] data;
    logic [9:0] word;
    logic [5:0] disp;
  } vec_t;

  exp_t       sb[$];
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;
  int         model_cnt = 0;
  logic [9:0] tok[4];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] rx_decode(input logic [9:0] w);
    logic [7:0] q;
    logic [7:0] d;
    q    = w[9] ? ~w[7:0] : w[7:0];
    d[0] = q[0];
    for (int i = 1; i < 8; i++) d[i] = w[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    return d;
  endfunction

  // Straight reading of the encoding algorithm, integer arithmetic for the disparity.
  task automatic model_sym(input logic [7:0] d, output logic [9:0] w);
    int         n1d, n1, n0, q8i;
    logic       xm;
    logic       q8;
    logic [7:0] qm;
    n1d   = $countones(d);
    xm    = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = xm ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    q8  = ~xm;
    q8i = q8 ? 1 : 0;
    n1  = $countones(qm);
    n0  = 8 - n1;
    if (model_cnt == 0 || n1 == n0) begin
      w = {~q8, q8, q8 ? qm : ~qm};
      model_cnt += q8 ? (n1 - n0) : (n0 - n1);
    end else if ((model_cnt > 0 && n1 > n0) || (model_cnt < 0 && n0 > n1)) begin
      w = {1'b1, q8, ~qm};
      model_cnt += 2 * q8i + n0 - n1;
    end else begin
      w = {1'b0, q8, qm};
      model_cnt += n1 - n0 - 2 * (1 - q8i);
    end
  endtask

  task automatic push_exp(input logic [9:0] w, input logic [5:0] dp, input bit hd, input logic [7:0] d);
    exp_t e;
    e.due      = cyc + 2;
    e.word     = w;
    e.disp     = dp;
    e.has_data = hd;
    e.data     = d;
    sb.push_back(e);
  endtask

  task automatic issue(input logic d_e, input logic [1:0] c, input logic [7:0] d,
                       input logic [9:0] w, input logic [5:0] dp);
    @(negedge clk);
    de   = d_e;
    ctl  = c;
    data = d;
    push_exp(w, dp, d_e, d);
  endtask

`ifdef TMDS_TERC4_EN
  task automatic issue_isl(input logic d_e, input logic [3:0] ax, input logic [7:0] d,
                           input logic [9:0] w, input logic [5:0] dp);
    @(negedge clk);
    de     = d_e;
    ctl    = 2'b00;
    data   = d;
    island = 1'b1;
    aux    = ax;
    push_exp(w, dp, d_e, d);
  endtask
`endif

  // Monitor: every symbol whose pipeline slot has arrived is compared at the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        check("word", word, e.word);
        check("disparity", {4'b0000, disp}, {4'b0000, e.disp});
        if (e.has_data) begin
          check("rx_decode", {2'b00, rx_decode(word)}, {2'b00, e.data});
          checks++;
          if ($signed(disp) > 6'sd10 || $signed(disp) < -6'sd10) begin
            errors++;
            $display("FAIL disparity_range: got %0d, required within +/-10", $signed(disp));
          end
        end
        $display("sym cyc=%0d data=%h word=%h disp=%0d", cyc, e.data, word, $signed(disp));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t       vecs[19];
    logic [9:0] w;
    logic [7:0] d;
    logic [1:0] c;
    int         wait_cycles;

    tok  = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
    vecs = '{
      '{1'b0, 2'b00, 8'h00, 10'h354, 6'h00},
      '{1'b0, 2'b01, 8'h00, 10'h0AB, 6'h00},
      '{1'b0, 2'b10, 8'h00, 10'h154, 6'h00},
      '{1'b0, 2'b11, 8'h00, 10'h2AB, 6'h00},
      '{1'b1, 2'b00, 8'h00, 10'h100, 6'h38},
      '{1'b1, 2'b00, 8'h00, 10'h3FF, 6'h02},
      '{1'b1, 2'b00, 8'h00, 10'h100, 6'h3A},
      '{1'b0, 2'b00, 8'h00, 10'h354, 6'h00},
      '{1'b1, 2'b00, 8'hFF, 10'h200, 6'h38},
      '{1'b0, 2'b00, 8'h00, 10'h354, 6'h00},
      '{1'b1, 2'b00, 8'h01, 10'h1FF, 6'h08},
      '{1'b1, 2'b00, 8'h01, 10'h300, 6'h02},
      '{1'b1, 2'b00, 8'hFF, 10'h200, 6'h3A},
      '{1'b1, 2'b00, 8'h55, 10'h133, 6'h3A},
      '{1'b1, 2'b00, 8'h00, 10'h3FF, 6'h04},
      '{1'b1, 2'b00, 8'h10, 10'h1F0, 6'h04},
      '{1'b1, 2'b00, 8'hFE, 10'h000, 6'h3A},
      '{1'b0, 2'b11, 8'h00, 10'h2AB, 6'h00},
      '{1'b1, 2'b00, 8'h00, 10'h100, 6'h38}
    };

    rst  = 1'b1;
    de   = 1'b0;
    ctl  = 2'b00;
    data = 8'h00;
`ifdef TMDS_TERC4_EN
    island = 1'b0;
    aux    = 4'h0;
`endif
    repeat (3) @(negedge clk);
    check("reset_word", word, 10'h354);
    check("reset_disp", {4'b0000, disp}, 10'h000);
    @(negedge clk);
    rst = 1'b0;

    issue(1'b0, 2'b00, 8'h00, 10'h354, 6'h00);
    issue(1'b0, 2'b00, 8'h00, 10'h354, 6'h00);
    foreach (vecs[i]) issue(vecs[i].de, vecs[i].ctl, vecs[i].data, vecs[i].word, vecs[i].disp);
    issue(1'b0, 2'b00, 8'h00, 10'h354, 6'h00);

    // Random burst with occasional blanking, expectations from the model.
    model_cnt = 0;
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 19) == 0) begin
        c = 2'($urandom_range(0, 3));
        model_cnt = 0;
        issue(1'b0, c, 8'h00, tok[c], 6'h00);
      end else begin
        d = 8'($urandom_range(0, 255));
        model_sym(d, w);
        issue(1'b1, 2'b00, d, w, model_cnt[5:0]);
      end
    end
    issue(1'b0, 2'b00, 8'h00, 10'h354, 6'h00);

    // Drain, then reset while a symbol is in flight.
    wait_cycles = 0;
    while (sb.size() > 0 && wait_cycles < 50) begin
      @(negedge clk);
      wait_cycles++;
    end
    @(negedge clk);
    de   = 1'b1;
    data = 8'h00;
    @(negedge clk);
    @(posedge clk);
    #1;
    check("pre_reset_word", word, 10'h100);
    check("pre_reset_disp", {4'b0000, disp}, 10'h038);
    #1;
    rst = 1'b1;
    #1;
    check("async_reset_word", word, 10'h354);
    check("async_reset_disp", {4'b0000, disp}, 10'h000);
    @(negedge clk);
    de = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    issue(1'b0, 2'b00, 8'h00, 10'h354, 6'h00);
    issue(1'b1, 2'b00, 8'h00, 10'h100, 6'h38);
    issue(1'b0, 2'b00, 8'h00, 10'h354, 6'h00);

`ifdef TMDS_TERC4_EN
    begin
      logic [9:0] terc[16];
      terc = '{10'h29C, 10'h263, 10'h2E4, 10'h2E2, 10'h171, 10'h11E, 10'h18E, 10'h13C,
               10'h2CC, 10'h139, 10'h19C, 10'h2C6, 10'h28E, 10'h271, 10'h163, 10'h2C3};
      for (int a = 0; a < 16; a++) issue_isl(1'b0, 4'(a), 8'h00, terc[a], 6'h00);
      issue_isl(1'b1, 4'h5, 8'h00, 10'h100, 6'h38);
      issue_isl(1'b0, 4'h3, 8'h00, 10'h2E2, 6'h00);
      @(negedge clk);
      island = 1'b0;
      de     = 1'b0;
      push_exp(10'h354, 6'h00, 1'b0, 8'h00);
    end
`endif

    wait_cycles = 0;
    while (sb.size() > 0 && wait_cycles < 100) begin
      @(negedge clk);
      wait_cycles++;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d symbols outstanding, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
